// File: rtl/bnn_accum_threshold.sv
// Accumulates adder-tree partial sums per neuron, thresholds the saturated total into a
// binary activation and packs activations LSB-first into PACK-bit output words.
module bnn_accum_threshold #(
   parameter int unsigned WIDTH_IN = 8,
   parameter int unsigned ACC_W    = 24,
   parameter int unsigned PACK     = 32,
   localparam int unsigned SUM_W   = WIDTH_IN + 11,
   localparam int unsigned CNT_W   = $clog2(PACK + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic signed [SUM_W-1:0] in_sum,
   input  logic                    in_valid,
   input  logic                    in_last,
   input  logic signed [ACC_W-1:0] thresh,
   input  logic                    invert,
   input  logic                    flush,
   output logic                    in_ready,
   output logic [PACK-1:0]         out_word,
   output logic [CNT_W-1:0]        out_count,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    ovf
);

   localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
   localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_e;

   state_e                  state_q, state_d;
   logic signed [ACC_W-1:0] acc_q, acc_d;
   logic [PACK-1:0]         pack_q, pack_d;
   logic [CNT_W-1:0]        idx_q, idx_d;
   logic [PACK-1:0]         word_q, word_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic                    ovf_q, ovf_d;

   logic                    accept;
   logic                    flush_take;
   logic [ACC_W:0]          sum_wide;
   logic                    sat_hi;
   logic                    sat_lo;
   logic signed [ACC_W-1:0] total;
   logic                    act_bit;
   logic [PACK-1:0]         pack_w;
   logic [CNT_W-1:0]        idx_w;
   logic                    emit;

   assign in_ready   = (state_q == FILL) || out_ready;
   assign accept     = in_valid && in_ready;
   assign flush_take = flush && in_ready;

   // One guard bit above the accumulator exposes overflow of the signed add.
   always_comb begin
      sum_wide = {acc_q[ACC_W-1], acc_q}
               + {{(ACC_W+1-SUM_W){in_sum[SUM_W-1]}}, in_sum};
      sat_hi   = !sum_wide[ACC_W] && sum_wide[ACC_W-1];
      sat_lo   = sum_wide[ACC_W] && !sum_wide[ACC_W-1];
      if (sat_hi)      total = ACC_MAX;
      else if (sat_lo) total = ACC_MIN;
      else             total = sum_wide[ACC_W-1:0];
      act_bit  = (total >= thresh) ^ invert;
   end

   // Next-state: accumulate, pack, emit and output-buffer handshake.
   always_comb begin
      state_d = state_q;
      acc_d   = acc_q;
      pack_d  = pack_q;
      idx_d   = idx_q;
      word_d  = word_q;
      count_d = count_q;
      ovf_d   = ovf_q;
      pack_w  = pack_q;
      idx_w   = idx_q;
      emit    = 1'b0;

      if (accept) begin
         if (sat_hi || sat_lo) ovf_d = 1'b1;
         if (in_last) begin
            acc_d  = '0;
            pack_w = pack_q | (PACK'(act_bit) << idx_q);
            idx_w  = idx_q + CNT_W'(1);
         end else begin
            acc_d  = total;
         end
      end

      emit = (idx_w == CNT_W'(PACK)) || (flush_take && (idx_w != '0));

      if (emit) begin
         word_d  = pack_w;
         count_d = idx_w;
         pack_d  = '0;
         idx_d   = '0;
         state_d = HOLD;
      end else begin
         pack_d  = pack_w;
         idx_d   = idx_w;
         if ((state_q == HOLD) && out_ready) state_d = FILL;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= FILL;
         acc_q   <= '0;
         pack_q  <= '0;
         idx_q   <= '0;
         word_q  <= '0;
         count_q <= '0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         acc_q   <= acc_d;
         pack_q  <= pack_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         count_q <= count_d;
         ovf_q   <= ovf_d;
      end
   end

   assign out_valid = (state_q == HOLD);
   assign out_word  = word_q;
   assign out_count = count_q;
   assign ovf       = ovf_q;

endmodule

// File: tb/tb_bnn_accum_threshold.sv
// Directed bench for bnn_accum_threshold: a PACK=32 instance and a PACK=4/ACC_W=20 instance,
// with per-instance scoreboards of expected output words.
module tb_bnn_accum_threshold;

   localparam int unsigned SW    = 19;
   localparam int unsigned A_AW  = 24;
   localparam int unsigned B_AW  = 20;
   localparam int unsigned A_CW  = 6;
   localparam int unsigned B_CW  = 3;

   logic clk;
   int   checks = 0;
   int   errors = 0;

   logic                   a_rst_n, a_in_valid, a_in_last, a_invert, a_flush, a_in_ready;
   logic                   a_out_valid, a_out_ready, a_ovf;
   logic signed [SW-1:0]   a_in_sum;
   logic signed [A_AW-1:0] a_thresh;
   logic [31:0]            a_out_word;
   logic [A_CW-1:0]        a_out_count;

   logic                   b_rst_n, b_in_valid, b_in_last, b_invert, b_flush, b_in_ready;
   logic                   b_out_valid, b_out_ready, b_ovf;
   logic signed [SW-1:0]   b_in_sum;
   logic signed [B_AW-1:0] b_thresh;
   logic [3:0]             b_out_word;
   logic [B_CW-1:0]        b_out_count;

   logic [31:0] qa_w[$];
   int          qa_c[$];
   logic [3:0]  qb_w[$];
   int          qb_c[$];
   logic [31:0] ma_pack;
   int          ma_idx;
   logic [3:0]  mb_pack;
   int          mb_idx;
   logic [31:0] pat;

   bnn_accum_threshold #(.WIDTH_IN(8), .ACC_W(24), .PACK(32)) a_dut (
      .clk(clk), .rst_n(a_rst_n), .in_sum(a_in_sum), .in_valid(a_in_valid),
      .in_last(a_in_last), .thresh(a_thresh), .invert(a_invert), .flush(a_flush),
      .in_ready(a_in_ready), .out_word(a_out_word), .out_count(a_out_count),
      .out_valid(a_out_valid), .out_ready(a_out_ready), .ovf(a_ovf));

   bnn_accum_threshold #(.WIDTH_IN(8), .ACC_W(20), .PACK(4)) b_dut (
      .clk(clk), .rst_n(b_rst_n), .in_sum(b_in_sum), .in_valid(b_in_valid),
      .in_last(b_in_last), .thresh(b_thresh), .invert(b_invert), .flush(b_flush),
      .in_ready(b_in_ready), .out_word(b_out_word), .out_count(b_out_count),
      .out_valid(b_out_valid), .out_ready(b_out_ready), .ovf(b_ovf));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Scoreboards: pop on every output handshake.
   always @(negedge clk) begin
      if (a_out_valid === 1'b1 && a_out_ready === 1'b1) begin
         checks++;
         assert (qa_w.size() != 0) else begin
            errors++;
            $error("FAIL a_unexpected_word observed %0h expected none", a_out_word);
         end
         if (qa_w.size() != 0) begin
            chk("a_sb_word", 64'(a_out_word), 64'(qa_w.pop_front()));
            chk("a_sb_count", 64'(a_out_count), 64'(qa_c.pop_front()));
         end
      end
      if (b_out_valid === 1'b1 && b_out_ready === 1'b1) begin
         checks++;
         assert (qb_w.size() != 0) else begin
            errors++;
            $error("FAIL b_unexpected_word observed %0h expected none", b_out_word);
         end
         if (qb_w.size() != 0) begin
            chk("b_sb_word", 64'(b_out_word), 64'(qb_w.pop_front()));
            chk("b_sb_count", 64'(b_out_count), 64'(qb_c.pop_front()));
         end
      end
   end

   task automatic a_chunk(input int sum, input bit last, input int thr, input bit inv,
                          input bit fl, input bit eb);
      a_in_sum   = SW'(sum);
      a_in_last  = last;
      a_thresh   = A_AW'(thr);
      a_invert   = inv;
      a_flush    = fl;
      a_in_valid = 1'b1;
      if (last) begin
         ma_pack[ma_idx] = eb;
         ma_idx++;
      end
      if (ma_idx == 32 || (fl && ma_idx > 0)) begin
         qa_w.push_back(ma_pack);
         qa_c.push_back(ma_idx);
         ma_pack = '0;
         ma_idx  = 0;
      end
      tick();
      a_in_valid = 1'b0;
      a_flush    = 1'b0;
      a_in_last  = 1'b0;
   endtask

   task automatic a_neuron(input bit b, input bit fl);
      a_chunk(b ? 10 : -10, 1'b1, 0, 1'b0, fl, b);
   endtask

   task automatic a_flush_only();
      a_flush = 1'b1;
      if (ma_idx > 0) begin
         qa_w.push_back(ma_pack);
         qa_c.push_back(ma_idx);
         ma_pack = '0;
         ma_idx  = 0;
      end
      tick();
      a_flush = 1'b0;
   endtask

   task automatic b_chunk(input int sum, input bit last, input int thr, input bit inv,
                          input bit eb);
      b_in_sum   = SW'(sum);
      b_in_last  = last;
      b_thresh   = B_AW'(thr);
      b_invert   = inv;
      b_in_valid = 1'b1;
      if (last) begin
         mb_pack[mb_idx] = eb;
         mb_idx++;
      end
      if (mb_idx == 4) begin
         qb_w.push_back(mb_pack);
         qb_c.push_back(mb_idx);
         mb_pack = '0;
         mb_idx  = 0;
      end
      tick();
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
   endtask

   task automatic b_neuron(input bit b);
      b_chunk(b ? 10 : -10, 1'b1, 0, 1'b0, b);
   endtask

   initial begin
      a_rst_n = 1'b0; a_in_valid = 1'b0; a_in_last = 1'b0; a_invert = 1'b0; a_flush = 1'b0;
      a_in_sum = '0; a_thresh = '0; a_out_ready = 1'b1;
      b_rst_n = 1'b0; b_in_valid = 1'b0; b_in_last = 1'b0; b_invert = 1'b0; b_flush = 1'b0;
      b_in_sum = '0; b_thresh = '0; b_out_ready = 1'b1;
      ma_pack = '0; ma_idx = 0; mb_pack = '0; mb_idx = 0;
      tick();
      tick();
      chk("a_rst_valid", 64'(a_out_valid), 0);
      chk("a_rst_word", 64'(a_out_word), 0);
      chk("a_rst_count", 64'(a_out_count), 0);
      chk("a_rst_ovf", 64'(a_ovf), 0);
      chk("a_rst_ready", 64'(a_in_ready), 1);
      chk("b_rst_valid", 64'(b_out_valid), 0);
      chk("b_rst_word", 64'(b_out_word), 0);
      chk("b_rst_count", 64'(b_out_count), 0);
      chk("b_rst_ovf", 64'(b_ovf), 0);
      a_rst_n = 1'b1;
      b_rst_n = 1'b1;
      tick();

      // Accumulate and threshold: 100 - 30 + 50 = 120.
      b_chunk(100, 1'b0, 0, 1'b0, 1'b0);
      b_chunk(-30, 1'b0, 0, 1'b0, 1'b0);
      chk("b_acc_mid", 64'(b_dut.acc_q), 70);
      b_chunk(50, 1'b1, 120, 1'b0, 1'b1);
      chk("b_acc_clr1", 64'(b_dut.acc_q), 0);
      b_chunk(100, 1'b0, 0, 1'b0, 1'b0);
      b_chunk(-30, 1'b0, 0, 1'b0, 1'b0);
      b_chunk(50, 1'b1, 121, 1'b0, 1'b0);
      chk("b_acc_clr2", 64'(b_dut.acc_q), 0);
      b_chunk(100, 1'b0, 0, 1'b0, 1'b0);
      b_chunk(-30, 1'b0, 0, 1'b0, 1'b0);
      b_chunk(50, 1'b1, 121, 1'b1, 1'b1);
      chk("b_acc_clr3", 64'(b_dut.acc_q), 0);
      chk("b_valid_pre", 64'(b_out_valid), 0);
      b_neuron(1'b1);
      chk("b_valid_lat1", 64'(b_out_valid), 1);
      chk("b_word_1101", 64'(b_out_word), 64'h0D);
      chk("b_count_4", 64'(b_out_count), 4);
      tick();
      chk("b_valid_drop", 64'(b_out_valid), 0);

      // Backpressure: second word stalls, chunks offered meanwhile must be ignored.
      b_out_ready = 1'b0;
      b_neuron(1'b0);
      b_neuron(1'b1);
      b_neuron(1'b1);
      b_neuron(1'b0);
      b_in_sum = SW'(10); b_in_last = 1'b1; b_thresh = '0; b_invert = 1'b0; b_in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         chk("b_stall_ready", 64'(b_in_ready), 0);
         chk("b_stall_valid", 64'(b_out_valid), 1);
         chk("b_stall_word", 64'(b_out_word), 64'h6);
         tick();
      end
      b_in_valid = 1'b0;
      b_in_last  = 1'b0;
      b_out_ready = 1'b1;
      tick();
      b_neuron(1'b1);
      b_neuron(1'b0);
      b_neuron(1'b0);
      b_neuron(1'b1);
      tick();

      // Saturation at ACC_W=20.
      b_chunk(262143, 1'b0, 0, 1'b0, 1'b0);
      b_chunk(262143, 1'b0, 0, 1'b0, 1'b0);
      chk("b_ovf_before", 64'(b_ovf), 0);
      b_chunk(262143, 1'b0, 0, 1'b0, 1'b0);
      chk("b_acc_clamp", 64'(b_dut.acc_q), 524287);
      chk("b_ovf_set", 64'(b_ovf), 1);
      b_chunk(262143, 1'b0, 0, 1'b0, 1'b0);
      b_chunk(262143, 1'b1, 524287, 1'b0, 1'b1);
      chk("b_acc_after_sat", 64'(b_dut.acc_q), 0);
      b_neuron(1'b0);
      b_neuron(1'b0);
      b_neuron(1'b1);
      tick();
      chk("b_ovf_sticky", 64'(b_ovf), 1);

      // Flush with a same-cycle last chunk.
      a_neuron(1'b1, 1'b0);
      a_neuron(1'b1, 1'b0);
      a_neuron(1'b0, 1'b0);
      a_neuron(1'b1, 1'b1);
      chk("a_flush_valid", 64'(a_out_valid), 1);
      chk("a_flush_word", 64'(a_out_word), 64'hB);
      chk("a_flush_count", 64'(a_out_count), 4);
      a_flush_only();
      chk("a_empty_flush1", 64'(a_out_valid), 0);
      tick();
      chk("a_empty_flush2", 64'(a_out_valid), 0);

      // Flush mid-neuron keeps the partial sum.
      a_chunk(40, 1'b0, 0, 1'b0, 1'b0, 1'b0);
      a_flush_only();
      chk("a_acc_kept", 64'(a_dut.acc_q), 40);
      chk("a_mid_flush_noout", 64'(a_out_valid), 0);
      a_chunk(10, 1'b1, 50, 1'b0, 1'b0, 1'b1);
      a_flush_only();
      chk("a_partial_count", 64'(a_out_count), 1);
      tick();

      // Reset mid-word discards the five pending bits.
      for (int i = 0; i < 5; i++) a_neuron(1'b1, 1'b0);
      a_rst_n = 1'b0;
      ma_pack = '0;
      ma_idx  = 0;
      tick();
      chk("a_midrst_valid", 64'(a_out_valid), 0);
      chk("a_midrst_acc", 64'(a_dut.acc_q), 0);
      a_rst_n = 1'b1;
      tick();
      pat = 32'h5A3C0F96;
      for (int i = 0; i < 32; i++) a_neuron(pat[i], 1'b0);
      chk("a_full_count", 64'(a_out_count), 32);
      chk("a_full_word", 64'(a_out_word), 64'h5A3C0F96);

      repeat (3) tick();
      chk("a_sb_drained", 64'(qa_w.size()), 0);
      chk("b_sb_drained", 64'(qb_w.size()), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bnn_accum_threshold.md
Name: bnn_accum_threshold

Overview:
- Downstream consumer of the 128-input adder tree.
- Accumulates successive tree sums (input-channel chunks) into one neuron pre-activation and applies a per-neuron batch-norm threshold to produce a binary activation.
- Packs activations LSB-first into PACK-bit words for the next layer's weight/activation buffer.
- Uses a valid/ready handshake on both sides with single-entry output buffering.

Parameters:
- WIDTH_IN, 8: tree input width; tree sum width SUM_W = WIDTH_IN+11 (derived, signed)
- ACC_W, 24: signed accumulator width; ACC_W >= SUM_W required
- PACK, 32: activation bits per output word; range 2..64

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- in_sum  in  SUM_W signed  partial sum from adder tree
- in_valid  in  1  in_sum/in_last/thresh/invert valid
- in_last  in  1  final chunk of current neuron
- thresh  in  ACC_W signed  neuron threshold; sampled only on accepted last chunk
- invert  in  1  invert activation (negative BN gamma); sampled with thresh
- flush  in  1  emit partially filled word; accepted only when in_ready=1
- in_ready  out  1  block can accept a chunk/flush this cycle
- out_word  out  PACK  packed activations, bit0 = earliest neuron
- out_count  out  $clog2(PACK+1)  number of valid bits in out_word
- out_valid  out  1  out_word/out_count valid
- out_ready  in  1  downstream accepts word
- ovf  out  1  sticky accumulator saturation flag

Behaviour:
- Reset (async assert, sync-to-clk release): acc=0, pack register=0, bit_idx=0, out_valid=0, out_word=0, out_count=0, ovf=0. Asserting reset mid-neuron or mid-word discards all partial state; there is no replay.
- in_ready = !out_valid || out_ready (combinational). Accept = in_valid && in_ready.
- Accepted, in_last=0: acc <= sat(acc + sext(in_sum)).
- Accepted, in_last=1:
  - total = sat(acc + sext(in_sum)).
  - bit = (total >= thresh) XOR invert.
  - Write bit at pack[bit_idx]; bit_idx++.
  - acc <= 0.
- sat: clamp to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets ovf=1 until reset. The clamped value is used for comparison.
- Word completion: when the written bit makes bit_idx reach PACK:
  - Next cycle: out_word = full pack, out_count = PACK, out_valid = 1.
  - pack cleared; bit_idx = 0.
  - Latency from accepting the last chunk to out_valid is 1 cycle.
- Flush (flush && in_ready):
  - Evaluated after the same-cycle accepted chunk, so a bit written that cycle is included.
  - If resulting bit_idx > 0: emit word with out_count = bit_idx, unused upper bits 0; clear pack and bit_idx.
  - If bit_idx = 0: no output.
  - acc is never touched by flush; a mid-neuron partial sum survives.
  - Flush does not require in_valid.
- Output register:
  - Holds out_word/out_count stable while out_valid && !out_ready.
  - out_valid && out_ready with a new word completing the same cycle: reload, out_valid stays 1 (back-to-back, no bubble).
  - out_valid && out_ready with no new word: out_valid <= 0.
- Stall: when out_valid && !out_ready, in_ready = 0. No chunk or flush is consumed, and acc/pack are frozen.
- Single-chunk neurons (in_last=1 on the first chunk) are legal; the threshold then applies to sext(in_sum) alone.
- State summary:
  - FILL: out_valid=0.
  - HOLD: out_valid=1, stalled.
  - Transitions: FILL->HOLD on word emit; HOLD->FILL on out_ready with no new emit; HOLD->HOLD on out_ready with emit.

Test Plan:
- Reset mid-word: with PACK=32, accept 5 neurons, assert rst_n=0 for one cycle, then send 32 neurons -> a single word, out_count=32, and the first 5 bits come only from post-reset neurons.
- Accumulate/threshold: chunks 100, -30, 50 (last), thresh=120, invert=0 -> bit=1. Repeat with thresh=121 -> bit=0. Repeat with thresh=121, invert=1 -> bit=1. acc is 0 afterwards each time.
- Packing: PACK=4 override, neurons yield bits 1,0,1,1 -> out_word=4'b1101, out_count=4, out_valid exactly 1 cycle after the 4th last chunk.
- Backpressure: PACK=4, hold out_ready=0 after the first word -> in_ready=0, out_word stable for 10 cycles, and input chunks presented during the stall are not consumed. Release -> the second word follows with no lost or duplicated bits.
- Flush: PACK=32, 3 neurons (bits 1,1,0), then flush=1 with a 4th last chunk (bit 1) in the same cycle -> out_word=32'h0000000B, out_count=4. A second flush with bit_idx=0 produces no output. Flush mid-neuron leaves acc intact.
- Saturation: ACC_W=20, WIDTH_IN=8, feed 5 chunks of +262143 -> acc clamps at 524287, ovf=1 and stays 1 after neuron completion; with thresh=524287 -> bit=1.
